// File: rtl/tff_pkg.sv
// rtl/tff_pkg.sv - mode constants shared by the T-FF counter bank and its users
package tff_pkg;

    localparam logic [1:0] MODE_TOGGLE = 2'd0;
    localparam logic [1:0] MODE_UP     = 2'd1;
    localparam logic [1:0] MODE_DOWN   = 2'd2;
    localparam logic [1:0] MODE_HOLD   = 2'd3;

endpackage

// File: rtl/tff_cell.sv
// rtl/tff_cell.sv - single T flip-flop with sync active-low reset and parallel load
module tff_cell (
    input  logic clk,
    input  logic rst,
    input  logic rst_val,
    input  logic ld,
    input  logic d,
    input  logic tog,
    output logic q
);

    always_ff @(posedge clk) begin
        if (!rst) begin
            q <= rst_val;
        end else if (ld) begin
            q <= d;
        end else if (tog) begin
            q <= ~q;
        end
    end

endmodule

// File: rtl/tff_counter_bank.sv
// rtl/tff_counter_bank.sv - WIDTH T-FF cells driven as toggle register or up/down counter
module tff_counter_bank
    import tff_pkg::*;
#(
    parameter int               WIDTH     = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    parameter bit               SATURATE  = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] t,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] q,
    output logic             tc
);

    logic [WIDTH-1:0] up_t;
    logic [WIDTH-1:0] dn_t;
    logic [WIDTH-1:0] t_int;
    logic             all_ones;
    logic             all_zeros;
    logic             at_limit;

    // Ripple prefix ANDs: bit i toggles when every lower bit is 1 (up) or 0 (down).
    // The carry out of the chain doubles as the limit detect.
    always_comb begin
        up_t      = '0;
        dn_t      = '0;
        all_ones  = 1'b1;
        all_zeros = 1'b1;
        for (int i = 0; i < WIDTH; i++) begin
            up_t[i]   = all_ones;
            dn_t[i]   = all_zeros;
            all_ones  = all_ones & q[i];
            all_zeros = all_zeros & ~q[i];
        end
    end

    always_comb begin
        t_int    = '0;
        at_limit = 1'b0;
        if (en && !load) begin
            case (mode)
                MODE_TOGGLE: t_int = t;
                MODE_UP: begin
                    at_limit = all_ones;
                    t_int    = (SATURATE && all_ones) ? '0 : up_t;
                end
                MODE_DOWN: begin
                    at_limit = all_zeros;
                    t_int    = (SATURATE && all_zeros) ? '0 : dn_t;
                end
                default: t_int = '0;
            endcase
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        tff_cell u_cell (
            .clk     (clk),
            .rst     (rst),
            .rst_val (RESET_VAL[i]),
            .ld      (load),
            .d       (load_val[i]),
            .tog     (t_int[i]),
            .q       (q[i])
        );
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            tc <= 1'b0;
        end else begin
            tc <= at_limit;
        end
    end

endmodule
